// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 32-bit data memory between the
// instruction-fetch port (if_*) and the load/store port (dm_*).
// Optional feature macro: MEM_ARB_BYTE_STORE_EN turns partial-word stores
// into a read phase (G_DM) followed by a merged-word write phase (G_DMW).
//
// Handshake: a requester raises req with stable addr/data and holds it
// until its one-cycle ack; read data is valid only in the ack cycle and the
// requester may drop req or start a new transaction in the cycle after ack.
module mem_arbiter #(
    parameter int ADDR_W      = 16,
    parameter bit DM_PRIORITY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_be,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_G_IF = 2'd1;
    localparam logic [1:0] S_G_DM = 2'd2;
`ifdef MEM_ARB_BYTE_STORE_EN
    localparam logic [1:0] S_G_DMW = 2'd3;
`endif

    logic [1:0] state_q, state_d;

`ifdef MEM_ARB_BYTE_STORE_EN
    logic [31:0] merged_q, merged_d;
    logic        partial_st;
    logic        empty_st;

    assign partial_st = dm_wr && (dm_be != 4'hF) && (dm_be != 4'h0);
    assign empty_st   = dm_wr && (dm_be == 4'h0);
`else
    // Byte enables have no effect when every store writes the full word.
    logic unused_be;
    assign unused_be = ^dm_be;
`endif

    assign dbg_state = state_q;

    // Next grant: tie-break from IDLE, strict alternation out of ack states.
    always_comb begin
        state_d = state_q;
`ifdef MEM_ARB_BYTE_STORE_EN
        merged_d = merged_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dm_req && (DM_PRIORITY || !if_req)) state_d = S_G_DM;
                else if (if_req)                       state_d = S_G_IF;
                else                                   state_d = S_IDLE;
            end
            S_G_IF: state_d = dm_req ? S_G_DM : S_IDLE;
            S_G_DM: begin
`ifdef MEM_ARB_BYTE_STORE_EN
                if (partial_st) begin
                    // Read phase: keep new bytes where enabled, old bytes elsewhere.
                    state_d = S_G_DMW;
                    for (int i = 0; i < 4; i++) begin
                        merged_d[8*i +: 8] = dm_be[i] ? dm_wdata[8*i +: 8]
                                                      : mem_rdata[8*i +: 8];
                    end
                end else begin
                    state_d = if_req ? S_G_IF : S_IDLE;
                end
`else
                state_d = if_req ? S_G_IF : S_IDLE;
`endif
            end
`ifdef MEM_ARB_BYTE_STORE_EN
            S_G_DMW: state_d = if_req ? S_G_IF : S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Grant register; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
`ifdef MEM_ARB_BYTE_STORE_EN
            merged_q <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MEM_ARB_BYTE_STORE_EN
            merged_q <= merged_d;
`endif
        end
    end

    // Memory pins and port responses from the granted port; all zero in reset.
    always_comb begin
        if_rdata   = 32'h0;
        if_ack     = 1'b0;
        dm_rdata   = 32'h0;
        dm_ack     = 1'b0;
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        if (!rst) begin
            case (state_q)
                S_G_IF: begin
                    mem_enable = 1'b1;
                    mem_addr   = if_addr;
                    if_rdata   = mem_rdata;
                    if_ack     = 1'b1;
                end
                S_G_DM: begin
                    if (!dm_wr) begin
                        mem_enable = 1'b1;
                        mem_addr   = dm_addr;
                        dm_rdata   = mem_rdata;
                        dm_ack     = 1'b1;
                    end
`ifdef MEM_ARB_BYTE_STORE_EN
                    else if (empty_st) begin
                        dm_ack = 1'b1;
                    end else if (partial_st) begin
                        mem_enable = 1'b1;
                        mem_addr   = dm_addr;
                    end
`endif
                    else begin
                        mem_enable = 1'b1;
                        mem_wr     = 1'b1;
                        mem_addr   = dm_addr;
                        mem_wdata  = dm_wdata;
                        dm_ack     = 1'b1;
                    end
                end
`ifdef MEM_ARB_BYTE_STORE_EN
                S_G_DMW: begin
                    mem_enable = 1'b1;
                    mem_wr     = 1'b1;
                    mem_addr   = dm_addr;
                    mem_wdata  = merged_q;
                    dm_ack     = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table for single transactions, plus
// contention and reset-mid-store sequences. Instance a uses DM_PRIORITY=1
// with a real memory model; instance b uses DM_PRIORITY=0 with a fixed
// address-derived read pattern.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;

  logic [31:0] if_rdata_a, dm_rdata_a, mem_wdata_a, mem_rdata_a;
  logic        if_ack_a, dm_ack_a, mem_enable_a, mem_wr_a;
  logic [15:0] mem_addr_a;
  logic [1:0]  dbg_state_a;

  logic [31:0] if_rdata_b, dm_rdata_b, mem_wdata_b, mem_rdata_b;
  logic        if_ack_b, dm_ack_b, mem_enable_b, mem_wr_b;
  logic [15:0] mem_addr_b;
  logic [1:0]  dbg_state_b;

  int n_cmp = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model for instance a ----------------
  logic [31:0] mem_a [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem_a[ld_idx] <= ld_data;
    else if (mem_enable_a && mem_wr_a) mem_a[mem_addr_a[11:2]] <= mem_wdata_a;
  end
  assign mem_rdata_a = mem_a[mem_addr_a[11:2]];
  assign mem_rdata_b = {16'hB0B0, mem_addr_b};

  mem_arbiter #(.ADDR_W(16), .DM_PRIORITY(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_a), .if_ack(if_ack_a),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata_a), .dm_ack(dm_ack_a),
    .mem_enable(mem_enable_a), .mem_wr(mem_wr_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .dbg_state(dbg_state_a)
  );

  mem_arbiter #(.ADDR_W(16), .DM_PRIORITY(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_b), .if_ack(if_ack_b),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata_b), .dm_ack(dm_ack_b),
    .mem_enable(mem_enable_b), .mem_wr(mem_wr_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .dbg_state(dbg_state_b)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [31:0] dwd;
    logic [3:0]  be;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_dm_ack;
    logic [31:0] e_dm_rdata;
    logic        e_en;
    logic        e_wr;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ir, input logic [15:0] ia,
                     input logic dr, input logic dw, input logic [15:0] da,
                     input logic [31:0] dwd, input logic [3:0] be,
                     input logic eia, input logic [31:0] eir,
                     input logic eda, input logic [31:0] edr,
                     input logic een, input logic ewr, input logic [1:0] est);
    vec_t v;
    v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.be = be; v.e_if_ack = eia; v.e_if_rdata = eir;
    v.e_dm_ack = eda; v.e_dm_rdata = edr; v.e_en = een; v.e_wr = ewr;
    v.e_state = est;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q_a[$];
  logic [1:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic ir, input logic [15:0] ia,
                       input logic dr, input logic dw, input logic [15:0] da,
                       input logic [31:0] dwd, input logic [3:0] be);
    rst = r; if_req = ir; if_addr = ia; dm_req = dr; dm_wr = dw;
    dm_addr = da; dm_wdata = dwd; dm_be = be;
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    preload(10'd4,   32'hDEADBEEF);  // 0x0010
    preload(10'd8,   32'h55AA55AA);  // 0x0020
    preload(10'd64,  32'h00000000);  // 0x0100
    preload(10'd128, 32'hAABBCCDD);  // 0x0200

    // rst ir ia     dr dw da      dwd           be     | ifa ifrd          dma dmrd          en wr st
    add(1, 1, 16'h10, 0, 0, 16'h0,   32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 1, 16'h10, 0, 0, 16'h0,   32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 1, 16'h10, 0, 0, 16'h0,   32'h0,        4'h0,  1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 2'd1);
    add(0, 0, 16'h0,  0, 0, 16'h0,   32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 1, 16'h10, 1, 0, 16'h20,  32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 1, 16'h10, 1, 0, 16'h20,  32'h0,        4'h0,  0, 32'h0,        1, 32'h55AA55AA, 1, 0, 2'd2);
    add(0, 1, 16'h10, 0, 0, 16'h0,   32'h0,        4'h0,  1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 2'd1);
    add(0, 0, 16'h0,  1, 1, 16'h100, 32'h12345678, 4'hF,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 0, 16'h0,  1, 1, 16'h100, 32'h12345678, 4'hF,  0, 32'h0,        1, 32'h0,        1, 1, 2'd2);
    add(0, 0, 16'h0,  1, 0, 16'h100, 32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 0, 16'h0,  1, 0, 16'h100, 32'h0,        4'h0,  0, 32'h0,        1, 32'h12345678, 1, 0, 2'd2);
    add(0, 0, 16'h0,  0, 0, 16'h0,   32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 0, 16'h0,  1, 1, 16'h200, 32'h00000011, 4'h1,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
`ifdef MEM_ARB_BYTE_STORE_EN
    add(0, 0, 16'h0,  1, 1, 16'h200, 32'h00000011, 4'h1,  0, 32'h0,        0, 32'h0,        1, 0, 2'd2);
    add(0, 0, 16'h0,  1, 1, 16'h200, 32'h00000011, 4'h1,  0, 32'h0,        1, 32'h0,        1, 1, 2'd3);
    add(0, 0, 16'h0,  1, 0, 16'h200, 32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 0, 16'h0,  1, 0, 16'h200, 32'h0,        4'h0,  0, 32'h0,        1, 32'hAABBCC11, 1, 0, 2'd2);
`else
    add(0, 0, 16'h0,  1, 1, 16'h200, 32'h00000011, 4'h1,  0, 32'h0,        1, 32'h0,        1, 1, 2'd2);
    add(0, 0, 16'h0,  1, 0, 16'h200, 32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
    add(0, 0, 16'h0,  1, 0, 16'h200, 32'h0,        4'h0,  0, 32'h0,        1, 32'h00000011, 1, 0, 2'd2);
    add(0, 0, 16'h0,  0, 0, 16'h0,   32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);
`endif
    add(0, 0, 16'h0,  0, 0, 16'h0,   32'h0,        4'h0,  0, 32'h0,        0, 32'h0,        0, 0, 2'd0);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].rst, vecs[i].ir, vecs[i].ia, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].dwd, vecs[i].be);
      @(negedge clk);
      check($sformatf("v%0d if_ack", i),     {31'h0, if_ack_a},     {31'h0, vecs[i].e_if_ack});
      check($sformatf("v%0d if_rdata", i),   if_rdata_a,            vecs[i].e_if_rdata);
      check($sformatf("v%0d dm_ack", i),     {31'h0, dm_ack_a},     {31'h0, vecs[i].e_dm_ack});
      check($sformatf("v%0d dm_rdata", i),   dm_rdata_a,            vecs[i].e_dm_rdata);
      check($sformatf("v%0d mem_enable", i), {31'h0, mem_enable_a}, {31'h0, vecs[i].e_en});
      check($sformatf("v%0d mem_wr", i),     {31'h0, mem_wr_a},     {31'h0, vecs[i].e_wr});
      check($sformatf("v%0d state", i),      {30'h0, dbg_state_a},  {30'h0, vecs[i].e_state});
    end

    // Contention: both ports held busy; a (dm first) and b (if first) alternate.
    exp_q_a.push_back(2'b00);
    exp_q_b.push_back(2'b00);
    for (int k = 1; k <= 10; k++) begin
      exp_q_a.push_back((k % 2 == 1) ? 2'b01 : 2'b10);
      exp_q_b.push_back((k % 2 == 1) ? 2'b10 : 2'b01);
    end
    for (int k = 0; k <= 10; k++) begin
      logic [1:0] ea, eb;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 16'h10, 1'b1, 1'b1, 16'h100, 32'h12345678, 4'hF);
      @(negedge clk);
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      check($sformatf("cont%0d acks_a", k), {30'h0, if_ack_a, dm_ack_a}, {30'h0, ea});
      check($sformatf("cont%0d acks_b", k), {30'h0, if_ack_b, dm_ack_b}, {30'h0, eb});
      check($sformatf("cont%0d mem_wr_a", k), {31'h0, mem_wr_a}, {31'h0, ea[0]});
      check($sformatf("cont%0d if_rdata_a", k), if_rdata_a, ea[1] ? 32'hDEADBEEF : 32'h0);
      check($sformatf("cont%0d if_rdata_b", k), if_rdata_b, eb[1] ? 32'hB0B00010 : 32'h0);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("cont_end state_a", {30'h0, dbg_state_a}, 32'h0);
    check("cont_end state_b", {30'h0, dbg_state_b}, 32'h0);

    // Reset asserted during the grant cycle of a store.
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h100, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_grant dm_ack",     {31'h0, dm_ack_a},     32'h0);
    check("rst_grant mem_enable", {31'h0, mem_enable_a}, 32'h0);
    check("rst_grant mem_wr",     {31'h0, mem_wr_a},     32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rst_after state",      {30'h0, dbg_state_a},  32'h0);
    check("rst_after dm_ack",     {31'h0, dm_ack_a},     32'h0);
    check("rst_after if_ack",     {31'h0, if_ack_a},     32'h0);
    check("rst_after mem_enable", {31'h0, mem_enable_a}, 32'h0);
    check("rst_after mem_addr",   {16'h0, mem_addr_a},   32'h0);
    check("rst_after mem_wdata",  mem_wdata_a,           32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h100, 32'h0, 4'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_load dm_ack",   {31'h0, dm_ack_a}, 32'h1);
    check("rst_load dm_rdata", dm_rdata_a,        32'h12345678);
    dm_req = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
